// File: rtl/fft32_frame_buffer.sv
// Ping-pong 32-sample input buffer for the 32-point FFT: collects serial samples, replays frames as 8 four-lane beats.
// Define FFT_BITREV_EN to store samples at bit-reversed addresses (DIT stage-0 ordering).
module fft32_frame_buffer #(
  parameter int nb   = 9,
  parameter int LEAD = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            S_VALID,
  output logic            S_READY,
  input  logic [nb-1:0]   S_RE,
  input  logic [nb-1:0]   S_IM,
  output logic            START,
  output logic            DVALID,
  output logic            DLAST,
  output logic [4*nb-1:0] DR,
  output logic [4*nb-1:0] DI
);

  typedef enum logic [1:0] {IDLE, STRT, WAIT, BURST} state_t;

  state_t          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wsel_q, wsel_d;
  logic            rsel_q, rsel_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [2:0]      beat_q, beat_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            wr_en;
  logic [4:0]      wphys;
  logic [4*nb-1:0] lane_re, lane_im;
  logic            start_q, dvalid_q, dlast_q;
  logic [4*nb-1:0] dr_q, di_q;

  // Bank b occupies entries {b, addr[4:0]}.
  logic [nb-1:0] mem_re [0:63];
  logic [nb-1:0] mem_im [0:63];

  assign S_READY = RST & ~full_q[wsel_q];
  assign wr_en   = S_VALID & S_READY;

`ifdef FFT_BITREV_EN
  assign wphys = {waddr_q[0], waddr_q[1], waddr_q[2], waddr_q[3], waddr_q[4]};
`else
  assign wphys = waddr_q;
`endif

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_re[{wsel_q, wphys}] <= S_RE;
      mem_im[{wsel_q, wphys}] <= S_IM;
    end
  end

  // Lanes are fetched for the beat that will be visible after the next edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_re[nb*gi +: nb] = mem_re[{rsel_q, beat_d, 2'(gi)}];
    assign lane_im[nb*gi +: nb] = mem_im[{rsel_q, beat_d, 2'(gi)}];
  end

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    waddr_d = waddr_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;

    if (wr_en) begin
      waddr_d = waddr_q + 5'd1;
      if (waddr_q == 5'd31) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rsel_q]) state_d = STRT;
      end
      STRT: begin
        if (LEAD == 1) begin
          state_d = BURST;
          beat_d  = 3'd0;
        end else begin
          state_d = WAIT;
          cnt_d   = 8'(LEAD - 2);
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = BURST;
          beat_d  = 3'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      BURST: begin
        if (beat_q == 3'd7) begin
          // Write side only ever targets the other bank, so this clear cannot collide with a set.
          full_d[rsel_q] = 1'b0;
          rsel_d         = ~rsel_q;
          state_d        = IDLE;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      full_q  <= 2'b00;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      waddr_q <= 5'd0;
      beat_q  <= 3'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      waddr_q <= waddr_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      start_q  <= 1'b0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      dr_q     <= '0;
      di_q     <= '0;
    end else begin
      start_q  <= (state_d == STRT);
      dvalid_q <= (state_d == BURST);
      dlast_q  <= (state_d == BURST) && (beat_d == 3'd7);
      if (state_d == BURST) begin
        dr_q <= lane_re;
        di_q <= lane_im;
      end
    end
  end

  assign START  = start_q;
  assign DVALID = dvalid_q;
  assign DLAST  = dlast_q;
  assign DR     = dr_q;
  assign DI     = di_q;

endmodule

// File: tb/tb_fft32_frame_buffer.sv
// Self-checking bench for fft32_frame_buffer: frame-level reference model plus directed timing checks.
module tb_fft32_frame_buffer;
  localparam int NB   = 9;
  localparam int LEAD = 2;

  logic            clk = 1'b0;
  logic            RST;
  logic            S_VALID;
  logic            S_READY;
  logic [NB-1:0]   S_RE, S_IM;
  logic            START, DVALID, DLAST;
  logic [4*NB-1:0] DR, DI;

  fft32_frame_buffer #(.nb(NB), .LEAD(LEAD)) dut (
    .CLK(clk), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY),
    .S_RE(S_RE), .S_IM(S_IM), .START(START), .DVALID(DVALID),
    .DLAST(DLAST), .DR(DR), .DI(DI)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int fill_cyc;
  int last_k;

  logic [NB-1:0]   sq_re[$], sq_im[$];
  logic [4*NB-1:0] exp_dr[$], exp_di[$];
  int              exp_k[$];
  int              start_q[$], beat0_q[$];
  logic [4*NB-1:0] last_dr, last_di, beat0_dr, beat7_dr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int perm(input int n);
`ifdef FFT_BITREV_EN
    return ((n & 1) << 4) | ((n & 2) << 2) | (n & 4) | ((n & 8) >> 2) | ((n & 16) >> 4);
`else
    return n;
`endif
  endfunction

  // Every 32 accepted samples form one frame; beat k lane j shows sample perm(4k+j).
  task automatic accept(input logic [NB-1:0] re, input logic [NB-1:0] im);
    logic [4*NB-1:0] br, bi;
    sq_re.push_back(re);
    sq_im.push_back(im);
    if (sq_re.size() == 32) begin
      for (int k = 0; k < 8; k++) begin
        for (int j = 0; j < 4; j++) begin
          br[NB*j +: NB] = sq_re[perm(4*k + j)];
          bi[NB*j +: NB] = sq_im[perm(4*k + j)];
        end
        exp_dr.push_back(br);
        exp_di.push_back(bi);
        exp_k.push_back(k);
      end
      sq_re.delete();
      sq_im.delete();
      fill_cyc = cyc;
    end
  endtask

  task automatic flush_model();
    sq_re.delete(); sq_im.delete();
    exp_dr.delete(); exp_di.delete(); exp_k.delete();
    last_dr = '0;
    last_di = '0;
  endtask

  task automatic tick();
    logic acc;
    logic [NB-1:0] re, im;
    logic [4*NB-1:0] edr, edi;
    int k;
    acc = RST && S_VALID && S_READY;
    re  = S_RE;
    im  = S_IM;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) accept(re, im);
    if (START) start_q.push_back(cyc);
    if (DVALID) begin
      if (exp_dr.size() == 0) begin
        chk("spurious_beat", 64'(DVALID), 64'd0);
      end else begin
        edr = exp_dr.pop_front();
        edi = exp_di.pop_front();
        k   = exp_k.pop_front();
        chk("beat_dr", 64'(DR), 64'(edr));
        chk("beat_di", 64'(DI), 64'(edi));
        chk("beat_dlast", 64'(DLAST), 64'(k == 7));
        if (k == 0) begin
          beat0_q.push_back(cyc);
          beat0_dr = DR;
        end
        if (k == 7) beat7_dr = DR;
        last_k = k;
      end
      last_dr = DR;
      last_di = DI;
    end else begin
      chk("hold_dr", 64'(DR), 64'(last_dr));
      chk("hold_di", 64'(DI), 64'(last_di));
      chk("dlast_idle", 64'(DLAST), 64'd0);
      last_k = -1;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_dr.size() != 0; i++) tick();
    if (exp_dr.size() != 0) chk("drain_timeout", 64'(exp_dr.size()), 64'd0);
    repeat (4) tick();
  endtask

  initial begin
    logic [4*NB-1:0] b0, b7;
    int acc_cnt;
    RST = 1'b0; S_VALID = 1'b0; S_RE = '0; S_IM = '0;
    flush_model();
    last_k = -1;

    // Reset held with valid asserted: nothing accepted, outputs quiet.
    S_VALID = 1'b1; S_RE = 9'h55; S_IM = 9'haa;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", 64'(S_READY), 64'd0);
      chk("rst_start", 64'(START), 64'd0);
      chk("rst_dvalid", 64'(DVALID), 64'd0);
      chk("rst_dr", 64'(DR), 64'd0);
      chk("rst_di", 64'(DI), 64'd0);
    end
    S_VALID = 1'b0;
    RST = 1'b1;
    repeat (6) tick();
    chk("rst_nothing_stored", 64'(start_q.size()), 64'd0);

    // Single frame n=0..31.
    start_q.delete(); beat0_q.delete();
    for (int n = 0; n < 32; n++) begin
      S_VALID = 1'b1; S_RE = NB'(n); S_IM = ~NB'(n);
      chk("t2_ready", 64'(S_READY), 64'd1);
      tick();
    end
    S_VALID = 1'b0;
    drain(60);
    chk("t2_start_count", 64'(start_q.size()), 64'd1);
    if (start_q.size() == 1 && beat0_q.size() == 1) begin
      chk("t2_start_lat", 64'(start_q[0] - fill_cyc), 64'd1);
      chk("t2_dvalid_lat", 64'(beat0_q[0] - start_q[0]), 64'(LEAD));
    end
`ifdef FFT_BITREV_EN
    b0 = {9'd24, 9'd8, 9'd16, 9'd0};
    b7 = {9'd31, 9'd15, 9'd23, 9'd7};
`else
    b0 = {9'd3, 9'd2, 9'd1, 9'd0};
    b7 = {9'd31, 9'd30, 9'd29, 9'd28};
`endif
    chk("t2_beat0_dr", 64'(beat0_dr), 64'(b0));
    chk("t2_beat7_dr", 64'(beat7_dr), 64'(b7));

    // Continuous streaming: 4 frames, valid always high.
    start_q.delete();
    for (int n = 0; n < 128; n++) begin
      S_VALID = 1'b1; S_RE = NB'($urandom); S_IM = NB'($urandom);
      chk("t3_ready", 64'(S_READY), 64'd1);
      tick();
    end
    S_VALID = 1'b0;
    drain(80);
    chk("t3_start_count", 64'(start_q.size()), 64'd4);
    for (int i = 1; i < start_q.size(); i++)
      chk("t3_start_gap", 64'(start_q[i] - start_q[i-1]), 64'd32);

    // Random gaps: 96 samples through both banks.
    acc_cnt = 0;
    for (int i = 0; i < 2000 && acc_cnt < 96; i++) begin
      S_VALID = 1'($urandom_range(0, 1)); S_RE = NB'($urandom); S_IM = NB'($urandom);
      if (S_VALID && S_READY) acc_cnt++;
      tick();
    end
    S_VALID = 1'b0;
    chk("t4_accepted", 64'(acc_cnt), 64'd96);
    drain(80);

    // Reset in the middle of a burst.
    for (int n = 0; n < 32; n++) begin
      S_VALID = 1'b1; S_RE = NB'($urandom); S_IM = NB'($urandom);
      tick();
    end
    S_VALID = 1'b0;
    for (int i = 0; i < 40 && last_k != 3; i++) tick();
    chk("t5_reached_beat3", 64'(last_k), 64'd3);
    RST = 1'b0;
    flush_model();
    tick();
    chk("t5_dvalid_after_rst", 64'(DVALID), 64'd0);
    chk("t5_dlast_after_rst", 64'(DLAST), 64'd0);
    RST = 1'b1;
    start_q.delete();
    repeat (12) tick();
    chk("t5_no_restart", 64'(start_q.size()), 64'd0);
    for (int n = 0; n < 32; n++) begin
      S_VALID = 1'b1; S_RE = NB'($urandom); S_IM = NB'($urandom);
      tick();
    end
    S_VALID = 1'b0;
    drain(60);
    chk("t5_clean_start", 64'(start_q.size()), 64'd1);
    if (start_q.size() == 1) chk("t5_start_lat", 64'(start_q[0] - fill_cyc), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
